// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code prefixes, FSM state encodings and
// a frame parity helper used by the keyboard front end.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [6:0] ASCII_NONE = 7'd0;

   typedef enum logic [1:0] {
      FR_IDLE  = 2'd0,
      FR_RECV  = 2'd1,
      FR_CHECK = 2'd2
   } frame_state_e;

   typedef enum logic [1:0] {
      DEC_WAIT     = 2'd0,
      DEC_GOT_F0   = 2'd1,
      DEC_GOT_E0   = 2'd2,
      DEC_GOT_E0F0 = 2'd3
   } dec_state_e;

   // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 scan code to 7-bit ASCII map (uppercase letters,
// digits and space). Unmapped codes return ASCII_NONE.
module ps2_scan_to_ascii
   import ps2_pkg::*;
(
   input  logic [7:0] code_i,
   output logic [6:0] ascii_o
);

   // Table lookup; anything not listed decodes to "no key".
   always_comb begin
      ascii_o = ASCII_NONE;
      case (code_i)
         8'h1C: ascii_o = 7'h41; // A
         8'h32: ascii_o = 7'h42; // B
         8'h21: ascii_o = 7'h43; // C
         8'h23: ascii_o = 7'h44; // D
         8'h24: ascii_o = 7'h45; // E
         8'h2B: ascii_o = 7'h46; // F
         8'h34: ascii_o = 7'h47; // G
         8'h33: ascii_o = 7'h48; // H
         8'h43: ascii_o = 7'h49; // I
         8'h3B: ascii_o = 7'h4A; // J
         8'h42: ascii_o = 7'h4B; // K
         8'h4B: ascii_o = 7'h4C; // L
         8'h3A: ascii_o = 7'h4D; // M
         8'h31: ascii_o = 7'h4E; // N
         8'h44: ascii_o = 7'h4F; // O
         8'h4D: ascii_o = 7'h50; // P
         8'h15: ascii_o = 7'h51; // Q
         8'h2D: ascii_o = 7'h52; // R
         8'h1B: ascii_o = 7'h53; // S
         8'h2C: ascii_o = 7'h54; // T
         8'h3C: ascii_o = 7'h55; // U
         8'h2A: ascii_o = 7'h56; // V
         8'h1D: ascii_o = 7'h57; // W
         8'h22: ascii_o = 7'h58; // X
         8'h35: ascii_o = 7'h59; // Y
         8'h1A: ascii_o = 7'h5A; // Z
         8'h45: ascii_o = 7'h30; // 0
         8'h16: ascii_o = 7'h31; // 1
         8'h1E: ascii_o = 7'h32; // 2
         8'h26: ascii_o = 7'h33; // 3
         8'h25: ascii_o = 7'h34; // 4
         8'h2E: ascii_o = 7'h35; // 5
         8'h36: ascii_o = 7'h36; // 6
         8'h3D: ascii_o = 7'h37; // 7
         8'h3E: ascii_o = 7'h38; // 8
         8'h46: ascii_o = 7'h39; // 9
         8'h29: ascii_o = 7'h20; // space
         default: ascii_o = ASCII_NONE;
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronises the raw PS/2 lines into clk,
// deframes 11-bit frames with a watchdog, and tracks make/break/extended
// prefixes to present a held ASCII key plus one-cycle event strobes.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
)(
   input  logic       clk,
   input  logic       resetn,
   input  logic       kb_clock,
   input  logic       kb_data,
   output logic [6:0] ascii,
   output logic       key_down,
   output logic       key_event,
   output logic       key_is_break,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic                   clk_prev_q;
   logic                   clk_s;
   logic                   data_s;
   logic                   fall_edge;

   frame_state_e           fr_state_q;
   logic [3:0]             bit_cnt_q;
   logic [8:0]             shift_q;
   logic [CNT_W-1:0]       wd_cnt_q;
   logic [7:0]             byte_q;
   logic                   byte_valid_q;
   logic                   frame_err_q;

   dec_state_e             dec_state_q;
   logic [6:0]             ascii_q;
   logic                   key_down_q;
   logic                   key_event_q;
   logic                   key_is_break_q;
   logic [6:0]             map_ascii;

   assign clk_s     = clk_sync_q[SYNC_STAGES-1];
   assign data_s    = dat_sync_q[SYNC_STAGES-1];
   assign fall_edge = clk_prev_q & ~clk_s;

   // Synchronisers for the asynchronous PS/2 lines; idle-high on reset so no false edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], kb_clock};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kb_data};
         clk_prev_q <= clk_s;
      end
   end

   // Frame FSM with watchdog. The check is resolved on the stop-bit edge so the
   // byte_valid / frame_err pulses are registered and appear in the CHECK cycle.
   always_ff @(posedge clk) begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (!resetn) begin
         fr_state_q <= FR_IDLE;
         bit_cnt_q  <= '0;
         wd_cnt_q   <= '0;
      end else begin
         case (fr_state_q)
            FR_IDLE: begin
               wd_cnt_q <= '0;
               if (fall_edge && !data_s) begin
                  fr_state_q <= FR_RECV;
                  bit_cnt_q  <= '0;
                  wd_cnt_q   <= CNT_W'(1);
               end
            end
            FR_RECV: begin
               if (fall_edge) begin
                  // Counter holds cycles elapsed since the most recent edge.
                  wd_cnt_q <= CNT_W'(1);
                  if (bit_cnt_q == 4'd9) begin
                     byte_q     <= shift_q[7:0];
                     fr_state_q <= FR_CHECK;
                     if (data_s && odd_parity_ok(shift_q[7:0], shift_q[8]))
                        byte_valid_q <= 1'b1;
                     else
                        frame_err_q  <= 1'b1;
                  end else begin
                     shift_q   <= {data_s, shift_q[8:1]};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end else if (wd_cnt_q == WD_LAST) begin
                  frame_err_q <= 1'b1;
                  fr_state_q  <= FR_IDLE;
                  wd_cnt_q    <= '0;
               end else begin
                  wd_cnt_q <= wd_cnt_q + CNT_W'(1);
               end
            end
            FR_CHECK: begin
               fr_state_q <= FR_IDLE;
               wd_cnt_q   <= '0;
            end
            default: fr_state_q <= FR_IDLE;
         endcase
      end
   end

   ps2_scan_to_ascii u_map (
      .code_i  (byte_q),
      .ascii_o (map_ascii)
   );

   // Decoder FSM: tracks F0/E0 prefixes and updates the held key and event strobes.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         dec_state_q    <= DEC_WAIT;
         ascii_q        <= ASCII_NONE;
         key_down_q     <= 1'b0;
         key_event_q    <= 1'b0;
         key_is_break_q <= 1'b0;
      end else begin
         key_event_q    <= 1'b0;
         key_is_break_q <= 1'b0;
         if (frame_err_q) begin
            dec_state_q <= DEC_WAIT;
         end else if (byte_valid_q) begin
            if (byte_q == PS2_EXT) begin
               dec_state_q <= DEC_GOT_E0;
            end else if (byte_q == PS2_BREAK && dec_state_q == DEC_WAIT) begin
               dec_state_q <= DEC_GOT_F0;
            end else if (byte_q == PS2_BREAK && dec_state_q == DEC_GOT_E0) begin
               dec_state_q <= DEC_GOT_E0F0;
            end else begin
               dec_state_q <= DEC_WAIT;
               case (dec_state_q)
                  DEC_WAIT: begin
                     // Typematic repeats of the held key produce no event.
                     if (map_ascii != ASCII_NONE && (!key_down_q || ascii_q != map_ascii)) begin
                        ascii_q     <= map_ascii;
                        key_down_q  <= 1'b1;
                        key_event_q <= 1'b1;
                     end
                  end
                  DEC_GOT_F0: begin
                     // Release of a non-held key is reported but leaves the held key alone.
                     if (map_ascii != ASCII_NONE) begin
                        key_event_q    <= 1'b1;
                        key_is_break_q <= 1'b1;
                        if (map_ascii == ascii_q) begin
                           ascii_q    <= ASCII_NONE;
                           key_down_q <= 1'b0;
                        end
                     end
                  end
                  default: ; // extended keys are swallowed
               endcase
            end
         end
      end
   end

   assign ascii        = ascii_q;
   assign key_down     = key_down_q;
   assign key_event    = key_event_q;
   assign key_is_break = key_is_break_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of PS/2 frames with expected
// event counts and held-key state, plus timed sequences for latency,
// watchdog timeout and mid-frame reset.
module tb_ps2_key_decoder;

   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       kb_clock = 1'b1;
   logic       kb_data = 1'b1;
   logic [6:0] ascii;
   logic       key_down;
   logic       key_event;
   logic       key_is_break;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int ev_cnt = 0;
   int brk_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   typedef struct {
      logic [7:0] code;
      bit         par_ok;
      bit         stop_ok;
      int         ev;
      int         brk;
      int         err;
      logic [6:0] asc;
      bit         kd;
   } vec_t;

   vec_t vecs[$];

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .kb_clock     (kb_clock),
      .kb_data      (kb_data),
      .ascii        (ascii),
      .key_down     (key_down),
      .key_event    (key_event),
      .key_is_break (key_is_break),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (key_event === 1'b1) ev_cnt++;
         if (key_event === 1'b1 && key_is_break === 1'b1) brk_cnt++;
         if (frame_err === 1'b1) err_cnt++;
         if (key_event === 1'b1 && frame_err === 1'b1) both_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      kb_data = b;
      tick(4);
      kb_clock = 1'b0;
      tick(8);
      kb_clock = 1'b1;
      tick(4);
   endtask

   task automatic send_frame(input logic [7:0] code, input bit par_ok, input bit stop_ok);
      logic par;
      par = par_ok ? ~(^code) : (^code);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(code[i]);
      send_bit(par);
      send_bit(stop_ok);
      kb_data = 1'b1;
      tick(8);
   endtask

   initial begin
      int e0, b0, r0;

      // Reset state
      tick(5);
      chk("rst_ascii", 32'(ascii), 32'h0);
      chk("rst_key_down", 32'(key_down), 32'h0);
      chk("rst_key_event", 32'(key_event), 32'h0);
      chk("rst_key_is_break", 32'(key_is_break), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      resetn = 1'b1;
      tick(5);

      // Exact latency: make 0x1C, key_event appears two cycles after the stop edge
      begin
         logic [7:0] c;
         c = 8'h1C;
         send_bit(1'b0);
         for (int i = 0; i < 8; i++) send_bit(c[i]);
         send_bit(~(^c));
         kb_data = 1'b1;
         tick(4);
         kb_clock = 1'b0;
         tick(3);
         chk("lat_ev_early", 32'(key_event), 32'h0);
         chk("lat_ascii_early", 32'(ascii), 32'h0);
         tick(1);
         chk("lat_ev", 32'(key_event), 32'h1);
         chk("lat_brk", 32'(key_is_break), 32'h0);
         chk("lat_ascii", 32'(ascii), 32'h41);
         chk("lat_kd", 32'(key_down), 32'h1);
         tick(1);
         chk("lat_ev_late", 32'(key_event), 32'h0);
         tick(3);
         kb_clock = 1'b1;
         tick(8);
         chk("lat_ev_total", 32'(ev_cnt), 32'h1);
      end

      // Table: code, par_ok, stop_ok, events, breaks, errors, ascii, key_down
      vecs.push_back('{8'hF0, 1, 1, 0, 0, 0, 7'h41, 1});
      vecs.push_back('{8'h1C, 1, 1, 1, 1, 0, 7'h00, 0});
      vecs.push_back('{8'h1C, 1, 1, 1, 0, 0, 7'h41, 1});
      vecs.push_back('{8'h1C, 1, 1, 0, 0, 0, 7'h41, 1});
      vecs.push_back('{8'h1C, 1, 1, 0, 0, 0, 7'h41, 1});
      vecs.push_back('{8'h1C, 1, 1, 0, 0, 0, 7'h41, 1});
      vecs.push_back('{8'h32, 1, 1, 1, 0, 0, 7'h42, 1});
      vecs.push_back('{8'hF0, 1, 1, 0, 0, 0, 7'h42, 1});
      vecs.push_back('{8'h1C, 1, 1, 1, 1, 0, 7'h42, 1});
      vecs.push_back('{8'h1C, 0, 1, 0, 0, 1, 7'h42, 1});
      vecs.push_back('{8'h16, 1, 1, 1, 0, 0, 7'h31, 1});
      vecs.push_back('{8'hE0, 1, 1, 0, 0, 0, 7'h31, 1});
      vecs.push_back('{8'h75, 1, 1, 0, 0, 0, 7'h31, 1});
      vecs.push_back('{8'hE0, 1, 1, 0, 0, 0, 7'h31, 1});
      vecs.push_back('{8'hF0, 1, 1, 0, 0, 0, 7'h31, 1});
      vecs.push_back('{8'h75, 1, 1, 0, 0, 0, 7'h31, 1});
      vecs.push_back('{8'hF0, 1, 1, 0, 0, 0, 7'h31, 1});
      vecs.push_back('{8'h1C, 1, 0, 0, 0, 1, 7'h31, 1});
      vecs.push_back('{8'h1C, 1, 1, 1, 0, 0, 7'h41, 1});
      vecs.push_back('{8'h75, 1, 1, 0, 0, 0, 7'h41, 1});
      vecs.push_back('{8'hF0, 1, 1, 0, 0, 0, 7'h41, 1});
      vecs.push_back('{8'h75, 1, 1, 0, 0, 0, 7'h41, 1});
      vecs.push_back('{8'hF0, 1, 1, 0, 0, 0, 7'h41, 1});
      vecs.push_back('{8'h32, 1, 1, 1, 1, 0, 7'h41, 1});

      foreach (vecs[i]) begin
         e0 = ev_cnt; b0 = brk_cnt; r0 = err_cnt;
         send_frame(vecs[i].code, vecs[i].par_ok, vecs[i].stop_ok);
         chk($sformatf("v%0d_events", i), 32'(ev_cnt - e0), 32'(vecs[i].ev));
         chk($sformatf("v%0d_breaks", i), 32'(brk_cnt - b0), 32'(vecs[i].brk));
         chk($sformatf("v%0d_errors", i), 32'(err_cnt - r0), 32'(vecs[i].err));
         chk($sformatf("v%0d_ascii", i), 32'(ascii), 32'(vecs[i].asc));
         chk($sformatf("v%0d_key_down", i), 32'(key_down), 32'(vecs[i].kd));
      end

      // Watchdog: start + 4 data bits, then the line stays high
      e0 = ev_cnt; r0 = err_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      kb_data = 1'b0;
      tick(4);
      kb_clock = 1'b0;
      tick(8);
      kb_clock = 1'b1;
      tick(TO - 7);
      chk("to_err_early", 32'(frame_err), 32'h0);
      tick(1);
      chk("to_err", 32'(frame_err), 32'h1);
      tick(1);
      chk("to_err_late", 32'(frame_err), 32'h0);
      chk("to_err_count", 32'(err_cnt - r0), 32'h1);
      chk("to_no_event", 32'(ev_cnt - e0), 32'h0);
      kb_data = 1'b1;
      tick(4);
      send_frame(8'h29, 1, 1);
      chk("to_next_ascii", 32'(ascii), 32'h20);
      chk("to_next_event", 32'(ev_cnt - e0), 32'h1);

      // Mid-frame reset discards the partial frame
      r0 = err_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      chk("mr_ascii", 32'(ascii), 32'h0);
      chk("mr_key_down", 32'(key_down), 32'h0);
      chk("mr_key_event", 32'(key_event), 32'h0);
      chk("mr_frame_err", 32'(frame_err), 32'h0);
      kb_data = 1'b1;
      tick(TO + 20);
      chk("mr_no_timeout", 32'(err_cnt - r0), 32'h0);
      e0 = ev_cnt;
      send_frame(8'h45, 1, 1);
      chk("mr_next_ascii", 32'(ascii), 32'h30);
      chk("mr_next_kd", 32'(key_down), 32'h1);
      chk("mr_next_event", 32'(ev_cnt - e0), 32'h1);

      chk("event_err_overlap", 32'(both_cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
